v3a_free_list_ctrl: RTL
=======================

Name: v3a_free_list_ctrl

Overview:
- Free-slot manager for the op-centric queue storage.
- Sequences one v3a_Mem1r1w instance as a circular FIFO of free slot indices. The memory resets to the identity contents, so all slots start free.
- Hands out slot IDs on an alloc val/rdy port and takes returned IDs on a free val/rdy port.
- Tracks per-slot allocated state to reject double frees and out-of-range frees.

Parameters:
- p_num_entries, 8, number of slots; must be >= 2; non-power-of-two allowed.
- p_addr_width, $clog2(p_num_entries), slot ID / pointer width.
- p_cnt_width, $clog2(p_num_entries+1), occupancy counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- alloc_val  out  1  a free slot ID is offered.
- alloc_rdy  in  1  consumer accepts alloc_id this cycle.
- alloc_id  out  p_addr_width  offered slot ID.
- free_val  in  1  returning a slot.
- free_rdy  out  1  controller can accept a free.
- free_id  in  p_addr_width  slot ID being returned.
- free_count  out  p_cnt_width  number of free slots held.
- err_bad_free  out  1  sticky error flag.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- State:
  - head_ptr and tail_ptr, p_addr_width each.
  - free_count.
  - alloc_map, p_num_entries bits, 1 = slot allocated.
  - err_bad_free.
- Reset values:
  - head_ptr = 0, tail_ptr = 0, free_count = p_num_entries.
  - alloc_map = 0, err_bad_free = 0.
  - The memory sub-module loads mem[i] = i.
  - After reset: alloc_val = 1, alloc_id = 0, free_rdy = 0.
- Reset mid-operation: all state returns to reset values next cycle; in-flight handshakes in the reset cycle are ignored.
- Alloc path:
  - alloc_val = (free_count != 0).
  - alloc_id = mem[head_ptr]. This is the combinational memory read with read_en = alloc_val; alloc_id = 0 when alloc_val = 0.
  - alloc_fire = alloc_val & alloc_rdy.
  - On fire: head_ptr advances; alloc_map[alloc_id] is set.
- Free path:
  - free_rdy = (free_count != p_num_entries).
  - free_ok = free_val & free_rdy & (free_id < p_num_entries) & alloc_map[free_id].
  - On free_ok: write mem[tail_ptr] = free_id, advance tail_ptr, clear alloc_map[free_id].
  - On free_val & free_rdy & !free_ok: the free is dropped and err_bad_free is set. The flag stays set until reset.
- Pointer wrap: ptr == p_num_entries-1 advances to 0 (explicit compare, not modulo-2^n).
- Counter update:
  - alloc_fire only: free_count -1.
  - free_ok only: free_count +1.
  - Both: unchanged, and both pointers advance.
- Simultaneous alloc and free of the same ID in one cycle:
  - The alloc_map check uses the pre-update value, so that free is bad and gets dropped.
  - The alloc still completes.
- Empty (free_count == 0):
  - A free written this cycle becomes visible on alloc_id next cycle. Memory write is registered; there is no same-cycle bypass.
  - alloc_val stays 0 in the free's cycle.
- Full (free_count == p_num_entries):
  - free_rdy = 0, so any free_val is ignored.
  - err_bad_free is not set, because the flag only sets on free_val & free_rdy.
- Latency: alloc ID is available 0 cycles after alloc_val rises; a returned ID is re-allocatable after all older free entries are consumed (FIFO order).

Decomposition:
- Shared package v3a_free_list_pkg holds:
  - a function computing the next pointer with wrap (ptr, num_entries).
  - the typedef slot_id_t sized from p_addr_width.
- Single sub-module: v3a_Mem1r1w with p_bit_width = p_addr_width.
  - write_en = free_ok, write_addr = tail_ptr, write_data = free_id.
  - read_en = alloc_val, read_addr = head_ptr.
- Pointer, counter, map and error logic are inline.

Test Plan:
1. Reset, then alloc_rdy = 1 for 8 cycles (N = 8) -> IDs 0..7 in order; free_count 8 -> 0; alloc_val = 0 on cycle 9; free_rdy = 1 from cycle 2.
2. From empty, free IDs 5, 2, 7 on consecutive cycles, then allocate 3 -> returns 5, 2, 7; alloc_val = 0 in the cycle of the first free and 1 the cycle after.
3. Allocate 4 (IDs 0–3), then assert alloc and free of ID 1 together for 1 cycle -> alloc returns 4, free_count stays 4, tail_ptr advances; next allocs give 5, 6, 7, 1.
4. After reset, free ID 3 (never allocated) with free_rdy forced by one prior alloc -> free dropped, err_bad_free = 1 and stays 1; free_count unchanged.
5. With N = 6 (non-power-of-two), allocate 6, free 6, allocate 6 -> pointers wrap 5 -> 0; IDs follow free order; no ID >= 6 ever appears on alloc_id.
6. Assert reset mid-stream with 3 allocated and err_bad_free set -> next cycle free_count = N, alloc_id = 0, err_bad_free = 0, alloc_map = 0.

Source files
------------

// File: rtl/v3a_free_list_pkg.sv
// +----------------------------------------------------------------------+
// | v3a_free_list_pkg                                                    |
// | Shared types and pointer helper for the free-slot manager.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package v3a_free_list_pkg;

  localparam int unsigned c_default_entries    = 8;
  localparam int unsigned c_default_addr_width = $clog2(c_default_entries);

  typedef logic [c_default_addr_width-1:0] slot_id_t;

  // Circular advance with an explicit compare so non-power-of-two depths wrap correctly.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned num_entries);
    return (ptr == num_entries - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/v3a_Mem1r1w.sv
// +----------------------------------------------------------------------+
// | v3a_Mem1r1w                                                          |
// | One combinational read port, one registered write port; resets to    |
// | identity contents (mem[i] = i).                                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module v3a_Mem1r1w #(
  parameter int p_bit_width   = 3,
  parameter int p_num_entries = 8,
  parameter int p_addr_width  = $clog2(p_num_entries)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    read_en,
  input  logic [p_addr_width-1:0] read_addr,
  output logic [p_bit_width-1:0]  read_data,
  input  logic                    write_en,
  input  logic [p_addr_width-1:0] write_addr,
  input  logic [p_bit_width-1:0]  write_data
);

  logic [p_bit_width-1:0] r_mem [p_num_entries];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < p_num_entries; i++) begin
        r_mem[i] <= p_bit_width'(i);
      end
    end else if (write_en) begin
      for (int i = 0; i < p_num_entries; i++) begin
        if (write_addr == p_addr_width'(i)) begin
          r_mem[i] <= write_data;
        end
      end
    end
  end

  // Decoded read keeps out-of-range addresses on non-power-of-two depths harmless.
  always_comb begin
    read_data = '0;
    if (read_en) begin
      for (int i = 0; i < p_num_entries; i++) begin
        if (read_addr == p_addr_width'(i)) begin
          read_data = r_mem[i];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/v3a_free_list_ctrl.sv
// +----------------------------------------------------------------------+
// | v3a_free_list_ctrl                                                   |
// | Free-slot FIFO manager: alloc/free val-rdy ports, double-free and    |
// | out-of-range detection with a sticky error flag.                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module v3a_free_list_ctrl
  import v3a_free_list_pkg::*;
#(
  parameter int p_num_entries = c_default_entries,
  parameter int p_addr_width  = $clog2(p_num_entries),
  parameter int p_cnt_width   = $clog2(p_num_entries + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    alloc_val,
  input  logic                    alloc_rdy,
  output logic [p_addr_width-1:0] alloc_id,
  input  logic                    free_val,
  output logic                    free_rdy,
  input  logic [p_addr_width-1:0] free_id,
  output logic [p_cnt_width-1:0]  free_count,
  output logic                    err_bad_free
);

  localparam int unsigned              c_num_entries = p_num_entries;
  localparam logic [p_cnt_width-1:0]   c_full_count  = p_cnt_width'(p_num_entries);

  logic [p_addr_width-1:0]  r_head_ptr;
  logic [p_addr_width-1:0]  r_tail_ptr;
  logic [p_cnt_width-1:0]   r_free_count;
  logic [p_num_entries-1:0] r_alloc_map;
  logic                     r_err_bad_free;

  logic                     w_alloc_fire;
  logic                     w_free_take;
  logic                     w_free_ok;
  logic                     w_id_in_range;
  logic                     w_map_hit;
  logic [p_num_entries-1:0] w_alloc_map_nxt;
  logic [p_addr_width-1:0]  w_head_nxt;
  logic [p_addr_width-1:0]  w_tail_nxt;

  assign alloc_val    = (r_free_count != '0);
  assign free_rdy     = (r_free_count != c_full_count);
  assign free_count   = r_free_count;
  assign err_bad_free = r_err_bad_free;

  assign w_alloc_fire  = alloc_val & alloc_rdy;
  assign w_free_take   = free_val & free_rdy;
  assign w_id_in_range = (32'(free_id) < c_num_entries);
  assign w_free_ok     = w_free_take & w_id_in_range & w_map_hit;

  assign w_head_nxt = p_addr_width'(next_ptr(32'(r_head_ptr), c_num_entries));
  assign w_tail_nxt = p_addr_width'(next_ptr(32'(r_tail_ptr), c_num_entries));

  v3a_Mem1r1w #(
    .p_bit_width   (p_addr_width),
    .p_num_entries (p_num_entries),
    .p_addr_width  (p_addr_width)
  ) u_mem (
    .clk        (clk),
    .reset      (reset),
    .read_en    (alloc_val),
    .read_addr  (r_head_ptr),
    .read_data  (alloc_id),
    .write_en   (w_free_ok),
    .write_addr (r_tail_ptr),
    .write_data (free_id)
  );

  // Map lookup uses the pre-update value, so a same-cycle alloc+free of one ID rejects the free.
  always_comb begin
    w_map_hit = 1'b0;
    for (int i = 0; i < p_num_entries; i++) begin
      if (free_id == p_addr_width'(i)) begin
        w_map_hit = r_alloc_map[i];
      end
    end
  end

  always_comb begin
    w_alloc_map_nxt = r_alloc_map;
    for (int i = 0; i < p_num_entries; i++) begin
      if (w_alloc_fire && (alloc_id == p_addr_width'(i))) begin
        w_alloc_map_nxt[i] = 1'b1;
      end
      if (w_free_ok && (free_id == p_addr_width'(i))) begin
        w_alloc_map_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head_ptr     <= '0;
      r_tail_ptr     <= '0;
      r_free_count   <= c_full_count;
      r_alloc_map    <= '0;
      r_err_bad_free <= 1'b0;
    end else begin
      if (w_alloc_fire) begin
        r_head_ptr <= w_head_nxt;
      end
      if (w_free_ok) begin
        r_tail_ptr <= w_tail_nxt;
      end
      case ({w_alloc_fire, w_free_ok})
        2'b10:   r_free_count <= r_free_count - 1'b1;
        2'b01:   r_free_count <= r_free_count + 1'b1;
        default: r_free_count <= r_free_count;
      endcase
      r_alloc_map <= w_alloc_map_nxt;
      if (w_free_take && !w_free_ok) begin
        r_err_bad_free <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
